// File: rtl/seq_multiplier.sv
// Multi-cycle RV32M multiply unit: walks one byte pair per cycle through an 8x8
// signed/unsigned array multiplier and accumulates shifted partials into a 2*WIDTH register.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int N  = WIDTH / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 2 * WIDTH;
    localparam int SW = IW + 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 8x8 multiply with per-operand signedness; low 16 bits of the extended product are exact
    function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] b,
                                           input logic a_sgn, input logic b_sgn);
        logic [15:0] ax;
        logic [15:0] bx;
        ax = {{8{a_sgn & a[7]}}, a};
        bx = {{8{b_sgn & b[7]}}, b};
        return ax * bx;
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;

    logic [7:0]      byte_a_s, byte_b_s;
    logic            a_sgn_s, b_sgn_s;
    logic [15:0]     pp_s;
    logic [AW-1:0]   ext_s, term_s, sum_s;
    logic [SW-1:0]   sh_s;
    logic            last_s;

    // Partial product for the current byte pair, placed at bit 8*(i+j)
    always_comb begin
        byte_a_s = a_q[{i_q, 3'b000} +: 8];
        byte_b_s = b_q[{j_q, 3'b000} +: 8];
        a_sgn_s  = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && (i_q == LAST_IDX);
        b_sgn_s  = (op_q == OP_MULH) && (j_q == LAST_IDX);
        pp_s     = mul8x8(byte_a_s, byte_b_s, a_sgn_s, b_sgn_s);
        ext_s    = {{(AW-16){(a_sgn_s | b_sgn_s) & pp_s[15]}}, pp_s};
        sh_s     = {1'b0, i_q, 3'b000} + {1'b0, j_q, 3'b000};
        term_s   = ext_s << sh_s;
        sum_s    = acc_q + term_s;
        last_s   = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            acc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'b00;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) state_d = S_BUSY;
                else                        state_d = S_IDLE;
            end
            S_BUSY: begin
                if (last_s) state_d = S_DONE;
                else        state_d = S_BUSY;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
                else           state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        i_d          = i_q;
        j_d          = j_q;
        acc_d        = acc_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    op_d       = in_op;
                    acc_d      = '0;
                    i_d        = '0;
                    j_d        = '0;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_BUSY: begin
                acc_d      = sum_s;
                in_ready_d = 1'b0;
                if (i_q == LAST_IDX) begin
                    i_d = '0;
                    if (j_q == LAST_IDX) begin
                        j_d          = '0;
                        out_valid_d  = 1'b1;
                        out_result_d = (op_q == OP_MUL) ? sum_s[WIDTH-1:0] : sum_s[AW-1:WIDTH];
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results, timing, backpressure and reset cases.
module tb_seq_multiplier;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: full signed/unsigned product in 64 bits, then select the half
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Reference model: idle/accept, 16-cycle compute, result held until taken
    logic        m_rdy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_res = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_rdy = 1'b0; m_valid = 1'b0; m_wait = 0; m_exp = '0; m_res = '0;
        end else if (m_rdy) begin
            if (in_valid) begin
                m_exp  = ref_mul(in_op, in_a, in_b);
                m_wait = 16;
                m_rdy  = 1'b0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = m_exp;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_rdy   = 1'b1;
            end
        end else begin
            m_rdy = 1'b1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (reset_n) begin
            check("cmp_in_ready", 64'(in_ready), 64'(m_rdy));
            check("cmp_out_valid", 64'(out_valid), 64'(m_valid));
            check("cmp_out_result", 64'(out_result), 64'(m_res));
        end else begin
            check("cmp_reset_outs", {30'd0, in_ready, out_valid, out_result}, 64'd0);
        end
    end

    task automatic wait_for(input bit want_valid, input string name);
        int k;
        k = 0;
        while (((want_valid ? out_valid : in_ready) !== 1'b1) && k < 60) begin
            @(negedge clock);
            k++;
        end
        if ((want_valid ? out_valid : in_ready) !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: signal low, expected high", name);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall, input string name);
        out_ready = (stall == 0);
        wait_for(1'b0, name);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clock);
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
        wait_for(1'b1, name);
        check(name, 64'(out_result), 64'(exp));
        repeat (stall) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int first_v;
        int first_r;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_ones");
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "mul_ones");
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, "mulh_ones");
        do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu_ones");
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min");
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 0, "mul_min");
        do_op(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 0, "mulh_max");
        do_op(2'b11, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 0, "mulhu_zero");

        // Back-to-back issue with in_valid held high
        wait_for(1'b0, "t_ready");
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd5; out_ready = 1'b1;
        @(posedge clock);
        first_v = -1; first_r = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (out_valid === 1'b1 && first_v < 0) begin
                first_v = k;
                check("t_first_result", 64'(out_result), 64'd15);
            end
            if (first_r >= 0 && k == first_r + 1) begin
                check("t_second_taken", 64'(in_ready), 64'd0);
                break;
            end
            if (in_ready === 1'b1 && first_r < 0) begin
                first_r = k;
                in_a = 32'd7; in_b = 32'd9;
            end
        end
        in_valid = 1'b0;
        check("t_latency", 64'(first_v), 64'd16);
        check("t_reissue_gap", 64'(first_r + 1 - first_v), 64'd2);
        wait_for(1'b1, "t_second");
        check("t_second_result", 64'(out_result), 64'd63);
        @(negedge clock);

        // Backpressure in DONE with an ignored request pulse
        out_ready = 1'b0;
        wait_for(1'b0, "bp_ready");
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'hFFFFFFF9; in_b = 32'h00000006;
        @(negedge clock);
        in_valid = 1'b0;
        wait_for(1'b1, "bp_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_result_hold", 64'(out_result), 64'hFFFFFFD6);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            if (k == 1) begin
                in_valid = 1'b1; in_op = 2'b11; in_a = 32'd1; in_b = 32'd1;
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_drop_valid", 64'(out_valid), 64'd0);
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        check("bp_not_queued", 64'(out_valid), 64'd0);
        check("bp_result_kept", 64'(out_result), 64'hFFFFFFD6);

        // Asynchronous reset with the counter at 7
        wait_for(1'b0, "rst_ready");
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'h80000000; in_b = 32'h80000000;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (7) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        do_op(2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 0, "mulhsu_after_rst");

        // Random operands with occasional stalls and edge values
        for (int t = 0; t < 1000; t++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (t % 10 == 0) a = 32'h00000000;
            if (t % 10 == 1) b = 32'h7FFFFFFF;
            if (t % 10 == 2) a = 32'h80000000;
            do_op(op, a, b, ref_mul(op, a, b), (t % 7 == 0) ? int'($urandom_range(1, 4)) : 0,
                  "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle multiply unit for the execute stage. Computes RV32M MUL/MULH/MULHSU/MULHU.
- Feeds one internal 8x8 Baugh-Wooley array multiplier (8-bit a/b, per-operand signed flags, 16-bit product as mul/mulh) with one byte pair per cycle.
- Sign-extends or zero-extends each 16-bit partial product, shifts it into place and accumulates it into a 2*WIDTH-bit register.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 32: operand/result width. Must be a multiple of 8 and >= 16. N = WIDTH/8 bytes per operand.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RISC-V funct3[1:0]).
- in_a  in  WIDTH  rs1 operand.
- in_b  in  WIDTH  rs2 operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  WIDTH  selected half of the product.

Behaviour:
- Reset: the clock is single, reset is asynchronous and active-low.
  - While reset_n=0: state=IDLE, counter=0, accumulator=0, captured operands/op=0, out_valid=0, out_result=0, in_ready=0.
  - in_ready=1 from the first edge after release.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a, in_b, in_op; clear accumulator; counter=0; go to BUSY.
  - Otherwise hold.
- BUSY (in_ready=0, out_valid=0):
  - Each cycle, i=counter mod N and j=counter div N.
  - Multiplier inputs: a=A[i], b=B[j].
  - a_is_signed = (op is MULH or MULHSU) & (i==N-1).
  - b_is_signed = (op is MULH) & (j==N-1).
  - Partial product P = {mulh, mul}.
  - Extend P to 2*WIDTH: sign-extend if a_is_signed|b_is_signed, else zero-extend.
  - Accumulator += extended P << 8*(i+j), modulo 2^(2*WIDTH).
  - counter += 1. On the edge where counter==N*N-1 is consumed, go to DONE.
  - The MUL op uses all-unsigned flags; the low WIDTH bits are identical for every op.
- DONE:
  - out_valid=1.
  - out_result = accumulator[WIDTH-1:0] for MUL, else accumulator[2*WIDTH-1:WIDTH].
  - out_result and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE.
  - out_valid drops the next cycle; out_result is held at its last value until the next DONE.
- Latency:
  - Accept edge E0; N*N BUSY edges; out_valid is high after edge E(N*N). For WIDTH=32 that is 16 cycles.
  - Minimum issue interval is N*N+2 cycles (the DONE handshake cycle plus the IDLE accept cycle).
- in_valid while in_ready=0 is ignored and not queued. in_a/in_b/in_op changes after acceptance have no effect.
- Asynchronous reset mid-BUSY or mid-DONE:
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight result is discarded; nothing partial appears on out_result.
- out_ready high in IDLE or BUSY has no effect.
- Accumulator overflow beyond 2*WIDTH bits wraps. This is correct two's-complement behaviour, because signed partials are sign-extended.

Test Plan:
- MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> out_result=0xFFFFFFFE. Same operands with MUL -> 0x00000001.
- MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF. MULH a=0x80000000 b=0x80000000 -> 0x40000000, MUL -> 0x00000000.
- Timing: in_valid held high with back-to-back requests.
  - Accept at edge 0 -> out_valid first high after edge 16, in_ready=0 on edges 1..16.
  - With out_ready=1, the second request is accepted exactly 2 cycles after out_valid rises.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_result and out_valid stable, in_ready=0, and a pulsed in_valid with new operands is ignored. out_ready=1 -> one transfer, then IDLE.
- Reset: reset_n low for 1 cycle at BUSY counter=7 -> out_valid=0, out_result=0 immediately. After release, MULHSU a=0xFFFFFFFE b=0x00000003 -> 0xFFFFFFFF (product -6).
- Random: 1000 random operand/op pairs compared against the 64-bit reference product. Includes a=0 and b=0x7FFFFFFF edge values.
